// File: rtl/fetch_pc_gen2.sv
// fetch_pc_gen2: instruction-fetch PC generator with absolute/relative jumps, return-address stack and sticky halt
// Ports:
//   CLK      - clock, all state updates on posedge
//   Init_n   - synchronous active-low reset
//   Stall    - hold PC, no stack activity
//   Done     - latch halt; PC frozen until reset
//   Branch   - PC <= Target << TGT_SHIFT
//   Target   - absolute target field (Branch, Call)
//   Jump_rel - PC <= PC + sign-extended Offset
//   Offset   - signed relative offset
//   Call     - push PC+1, then jump to absolute target
//   Ret      - pop return address into PC
//   PC       - current program counter
//   Halted   - Done has been accepted
//   Ras_ovf  - sticky: Call with stack full
//   Ras_unf  - sticky: Ret with stack empty
module fetch_pc_gen2 #(
    parameter int PC_W      = 8,
    parameter int TGT_W     = 3,
    parameter int TGT_SHIFT = 5,
    parameter int OFF_W     = 5,
    parameter int RAS_DEPTH = 4
) (
    input  logic             CLK,
    input  logic             Init_n,
    input  logic             Stall,
    input  logic             Done,
    input  logic             Branch,
    input  logic [TGT_W-1:0] Target,
    input  logic             Jump_rel,
    input  logic [OFF_W-1:0] Offset,
    input  logic             Call,
    input  logic             Ret,
    output logic [PC_W-1:0]  PC,
    output logic             Halted,
    output logic             Ras_ovf,
    output logic             Ras_unf
);
    localparam int PTR_W = $clog2(RAS_DEPTH + 1);
    localparam int IDX_W = RAS_DEPTH > 1 ? $clog2(RAS_DEPTH) : 1;

    logic [PC_W-1:0]  ras [RAS_DEPTH];
    logic [PTR_W-1:0] ptr, ptr_dec;
    logic [PC_W-1:0]  abs_tgt, rel_tgt, seq;
    logic             empty, full;

    // Truncating Target before the shift keeps the same low PC_W bits as shifting first.
    assign abs_tgt = PC_W'(Target) << TGT_SHIFT;
    assign rel_tgt = PC + PC_W'($signed(Offset));
    assign seq     = PC + PC_W'(1);
    assign empty   = ptr == '0;
    assign full    = ptr == PTR_W'(RAS_DEPTH);
    assign ptr_dec = ptr - PTR_W'(1);

    always_ff @(posedge CLK) begin
        if (!Init_n) begin
            PC      <= '0;
            Halted  <= 1'b0;
            Ras_ovf <= 1'b0;
            Ras_unf <= 1'b0;
            ptr     <= '0;
        end else if (Halted || Done) begin
            Halted <= 1'b1;
        end else if (!Stall) begin
            if (Ret) begin
                if (empty) begin
                    PC      <= seq;
                    Ras_unf <= 1'b1;
                end else begin
                    PC  <= ras[IDX_W'(ptr_dec)];
                    ptr <= ptr_dec;
                end
            end else if (Call) begin
                PC <= abs_tgt;
                if (full) begin
                    Ras_ovf <= 1'b1;
                end else begin
                    ras[IDX_W'(ptr)] <= seq;
                    ptr              <= ptr + PTR_W'(1);
                end
            end else begin
                PC <= Branch ? abs_tgt : Jump_rel ? rel_tgt : seq;
            end
        end
    end
endmodule

// File: tb/tb_fetch_pc_gen2.sv
// tb_fetch_pc_gen2: directed self-checking bench for fetch_pc_gen2 (default parameters)
module tb_fetch_pc_gen2;
    logic       CLK = 1'b0;
    logic       Init_n, Stall, Done, Branch, Jump_rel, Call, Ret;
    logic [2:0] Target;
    logic [4:0] Offset;
    logic [7:0] PC;
    logic       Halted, Ras_ovf, Ras_unf;
    int         tests = 0;
    int         fails = 0;

    fetch_pc_gen2 dut (
        .CLK(CLK), .Init_n(Init_n), .Stall(Stall), .Done(Done), .Branch(Branch),
        .Target(Target), .Jump_rel(Jump_rel), .Offset(Offset), .Call(Call), .Ret(Ret),
        .PC(PC), .Halted(Halted), .Ras_ovf(Ras_ovf), .Ras_unf(Ras_unf)
    );

    always #5 CLK = ~CLK;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle;
        Stall = 0; Done = 0; Branch = 0; Jump_rel = 0; Call = 0; Ret = 0;
        Target = '0; Offset = '0;
    endtask

    task automatic do_reset;
        idle();
        Init_n = 0;
        tick();
        Init_n = 1;
    endtask

    task automatic run(input int n);
        idle();
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset;
        idle();
        Init_n = 0;
        tick();
        tick();
        tests++; if (PC !== 8'd0) begin fails++; $display("FAIL reset_pc got %0d want 0", PC); end
        tests++; if (Halted !== 1'b0) begin fails++; $display("FAIL reset_halted got %b want 0", Halted); end
        tests++; if (Ras_ovf !== 1'b0) begin fails++; $display("FAIL reset_ovf got %b want 0", Ras_ovf); end
        tests++; if (Ras_unf !== 1'b0) begin fails++; $display("FAIL reset_unf got %b want 0", Ras_unf); end
        Init_n = 1;
    endtask

    task automatic test_free_run;
        logic [7:0] e;
        idle();
        for (int i = 1; i <= 257; i++) begin
            tick();
            e = 8'(i);
            tests++; if (PC !== e) begin fails++; $display("FAIL free_run step %0d got %0d want %0d", i, PC, e); end
        end
        tests++; if (Halted !== 1'b0) begin fails++; $display("FAIL free_run_halted got %b want 0", Halted); end
    endtask

    task automatic test_jumps;
        do_reset();
        run(10);
        tests++; if (PC !== 8'd10) begin fails++; $display("FAIL jump_pre got %0d want 10", PC); end
        Branch = 1; Target = 3'd3;
        tick();
        tests++; if (PC !== 8'd96) begin fails++; $display("FAIL branch_abs got %0d want 96", PC); end
        idle(); Jump_rel = 1; Offset = 5'b11100;
        tick();
        tests++; if (PC !== 8'd92) begin fails++; $display("FAIL jump_rel_neg got %0d want 92", PC); end
        Offset = 5'b00111;
        tick();
        tests++; if (PC !== 8'd99) begin fails++; $display("FAIL jump_rel_pos got %0d want 99", PC); end
        do_reset();
        run(2);
        Jump_rel = 1; Offset = 5'b11100;
        tick();
        tests++; if (PC !== 8'd254) begin fails++; $display("FAIL jump_rel_wrap got %0d want 254", PC); end
        idle(); Branch = 1; Jump_rel = 1; Target = 3'd7; Offset = 5'b00001;
        tick();
        tests++; if (PC !== 8'd224) begin fails++; $display("FAIL branch_over_rel got %0d want 224", PC); end
    endtask

    task automatic test_call_ret;
        do_reset();
        run(5);
        Call = 1; Target = 3'd1;
        tick();
        tests++; if (PC !== 8'd32) begin fails++; $display("FAIL call1 got %0d want 32", PC); end
        run(1);
        tests++; if (PC !== 8'd33) begin fails++; $display("FAIL call_seq got %0d want 33", PC); end
        Call = 1; Target = 3'd2;
        tick();
        tests++; if (PC !== 8'd64) begin fails++; $display("FAIL call2 got %0d want 64", PC); end
        idle(); Ret = 1;
        tick();
        tests++; if (PC !== 8'd34) begin fails++; $display("FAIL ret1 got %0d want 34", PC); end
        tick();
        tests++; if (PC !== 8'd6) begin fails++; $display("FAIL ret2 got %0d want 6", PC); end
        tests++; if ({Ras_ovf, Ras_unf} !== 2'b00) begin fails++; $display("FAIL nest_flags got %b want 00", {Ras_ovf, Ras_unf}); end
    endtask

    task automatic test_ras_bounds;
        logic [7:0] ret_exp [4];
        ret_exp = '{8'd97, 8'd65, 8'd33, 8'd1};
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            idle(); Call = 1; Target = 3'(i);
            tick();
            tests++; if (PC !== 8'(i * 32)) begin fails++; $display("FAIL call_chain %0d got %0d want %0d", i, PC, i * 32); end
            if (i == 4) begin
                tests++; if (Ras_ovf !== 1'b0) begin fails++; $display("FAIL ovf_early got %b want 0", Ras_ovf); end
            end
        end
        tests++; if (Ras_ovf !== 1'b1) begin fails++; $display("FAIL ovf_set got %b want 1", Ras_ovf); end
        idle(); Ret = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            tests++; if (PC !== ret_exp[i]) begin fails++; $display("FAIL ret_lifo %0d got %0d want %0d", i, PC, ret_exp[i]); end
        end
        tests++; if (Ras_unf !== 1'b0) begin fails++; $display("FAIL unf_early got %b want 0", Ras_unf); end
        tick();
        tests++; if (PC !== 8'd2) begin fails++; $display("FAIL ret_empty_pc got %0d want 2", PC); end
        tests++; if (Ras_unf !== 1'b1) begin fails++; $display("FAIL unf_set got %b want 1", Ras_unf); end
        tests++; if (Ras_ovf !== 1'b1) begin fails++; $display("FAIL ovf_sticky got %b want 1", Ras_ovf); end
    endtask

    task automatic test_priority;
        do_reset();
        run(3);
        Stall = 1; Call = 1; Branch = 1; Target = 3'd7;
        tick();
        tests++; if (PC !== 8'd3) begin fails++; $display("FAIL stall_hold got %0d want 3", PC); end
        run(1);
        tests++; if (PC !== 8'd4) begin fails++; $display("FAIL stall_release got %0d want 4", PC); end
        Ret = 1;
        tick();
        tests++; if (PC !== 8'd5 || Ras_unf !== 1'b1) begin fails++; $display("FAIL stall_no_push got pc=%0d unf=%b want pc=5 unf=1", PC, Ras_unf); end
        do_reset();
        Call = 1; Target = 3'd1;
        tick();
        Call = 1; Ret = 1; Target = 3'd2;
        tick();
        tests++; if (PC !== 8'd1) begin fails++; $display("FAIL call_ret_pop got %0d want 1", PC); end
        idle(); Ret = 1;
        tick();
        tests++; if (PC !== 8'd2 || Ras_unf !== 1'b1) begin fails++; $display("FAIL call_ret_no_push got pc=%0d unf=%b want pc=2 unf=1", PC, Ras_unf); end
    endtask

    task automatic test_done;
        do_reset();
        Ret = 1;
        tick();
        run(1);
        tests++; if (PC !== 8'd2) begin fails++; $display("FAIL done_pre got %0d want 2", PC); end
        Done = 1;
        tick();
        tests++; if (PC !== 8'd2 || Halted !== 1'b1) begin fails++; $display("FAIL done_accept got pc=%0d halted=%b want pc=2 halted=1", PC, Halted); end
        for (int i = 0; i < 6; i++) begin
            idle();
            Branch = i[0]; Call = i[1]; Ret = i[2]; Jump_rel = ~i[0]; Stall = (i == 5); Target = 3'd5; Offset = 5'd3;
            tick();
            tests++; if (PC !== 8'd2 || Halted !== 1'b1) begin fails++; $display("FAIL done_frozen %0d got pc=%0d halted=%b want pc=2 halted=1", i, PC, Halted); end
        end
        idle(); Init_n = 0; Call = 1; Ret = 1; Target = 3'd4;
        tick();
        tests++; if (PC !== 8'd0 || Halted !== 1'b0) begin fails++; $display("FAIL halt_reset got pc=%0d halted=%b want pc=0 halted=0", PC, Halted); end
        tests++; if ({Ras_ovf, Ras_unf} !== 2'b00) begin fails++; $display("FAIL flags_reset got %b want 00", {Ras_ovf, Ras_unf}); end
        idle(); Init_n = 1; Ret = 1;
        tick();
        tests++; if (PC !== 8'd1 || Ras_unf !== 1'b1) begin fails++; $display("FAIL reset_no_push got pc=%0d unf=%b want pc=1 unf=1", PC, Ras_unf); end
    endtask

    initial begin
        idle();
        Init_n = 1;
        test_reset();
        test_free_run();
        test_jumps();
        test_call_ret();
        test_ras_bounds();
        test_priority();
        test_done();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
